m_uxa_ps2_txreg: RTL and testbench
==================================

// Module: m_uxa_ps2_txreg
// PURPOSE
//  Host-to-device PS/2 transmitter. Serializes one command byte (e.g. 0xED set-LEDs, 0xF4 enable)
//  onto the open-drain PS/2 clock/data pair, with odd parity. Checks the device ACK bit.
//  Sits beside the UXA PS/2 receive shift register in the ps2io block.
//  busy_o lets the owner discard receive frames while a transmission is on the wire.
// PARAMETERS
//  INHIBIT_CYC  6000    sys_clk cycles the clock line is held low before start (120 us @ 50 MHz)
//  TIMEOUT_CYC  750000  max sys_clk cycles between device clock edges before error (15 ms @ 50 MHz)
//  CNT_W        20      width of the shared inhibit/timeout counter; must hold TIMEOUT_CYC
// PORTS
//  sys_clk_i    in   1  system clock; the only clock
//  reset_i      in   1  reset; synchronous, active-low (0 = reset)
//  d_i          in   8  byte to send; captured on accepted we_i
//  we_i         in   1  send request; accepted only when busy_o=0
//  busy_o       out  1  1 from the cycle after acceptance until done_o/err_o
//  done_o       out  1  1-cycle pulse: frame sent and device ACKed
//  err_o        out  1  1-cycle pulse: timeout or missing ACK
//  ps2_c_i      in   1  PS/2 clock pin level (asynchronous)
//  ps2_d_i      in   1  PS/2 data pin level (asynchronous)
//  ps2_c_oe_o   out  1  1 = pull clock low; 0 = release (pad is open-drain)
//  ps2_d_oe_o   out  1  1 = pull data low; 0 = release
// BEHAVIOUR
//  Reset (reset_i=0 at a clock edge): state=IDLE; busy_o, done_o, err_o, ps2_c_oe_o, ps2_d_oe_o = 0.
//   Sync flops are set to 1. Reset mid-frame releases both lines on the next edge; no done/err.
//  Pins pass through a 2-flop synchronizer. fall_evt = prev & ~curr on the synced clock (1 cycle).
//  Frame register tx[9:0] = {1'b1 stop, ~^d_i parity, d_i[7:0]}. Bits go out LSB first.
//  States:
//   IDLE    : oe both 0. On we_i: capture d_i, clear cnt, go to INHIBIT. busy_o=1 from the next cycle.
//   INHIBIT : c_oe=1. At cnt==INHIBIT_CYC-1: d_oe=1 (start bit), cnt=0, go to SETUP.
//   SETUP   : c_oe=1, d_oe=1 for exactly 1 cycle. Next: release clock (c_oe=0), bitcnt=0, go to SHIFT.
//   SHIFT   : on fall_evt: d_oe <= ~tx[bitcnt]; bitcnt++.
//             Fall edges 1..8 drive data bits, 9 drives parity, 10 drives stop (releases data).
//             After edge 10, go to ACK.
//   ACK     : on the next fall_evt, sample synced data. 0 means ACK: go to RELEASE. 1 means err: go to FAIL.
//   RELEASE : wait until synced clock=1 and data=1, then pulse done_o and go to IDLE.
//   FAIL    : oe both 0. Pulse err_o for 1 cycle, then go to IDLE.
//  Timeout: in SHIFT, ACK and RELEASE, cnt clears on every fall_evt (SHIFT/ACK) or state entry.
//   cnt==TIMEOUT_CYC-1 goes to FAIL.
//  busy_o drops in the same cycle that done_o or err_o is high.
//   A new we_i is accepted in the first cycle busy_o=0.
//  we_i while busy_o=1 is ignored, and d_i is not re-sampled.
//  done_o and err_o are never high together.
//  The block never drives a line high; oe=0 means released (pull-up).
//  Host-driven data changes happen only in the cycle after fall_evt; data is stable while clock is high.
// STRUCTURE
//  Shared include uxa_ps2_defs.vh holds:
//   - state encodings (3-bit, 7 states)
//   - PS2_FRAME_BITS=11
//   - default INHIBIT_CYC and TIMEOUT_CYC
//  Sub-module m_uxa_ps2_edgedet: 2-flop sync of clock and data.
//   Outputs are synced levels plus rise/fall pulses. It is reusable by the receive path.
//  The top holds the FSM, tx[9:0], bitcnt[3:0] and cnt[CNT_W-1:0].
// TESTING
//  Bench device model: clock period 80 us, drives clock low 40 us. Host data is sampled on rising edges.
//  Run with INHIBIT_CYC=60 and TIMEOUT_CYC=2000 to shorten sims.
//  1. we_i with d_i=0xED:
//     - c_oe=1 for 60 cycles, then d_oe=1 plus 1 SETUP cycle.
//     - Device captures start=0, bits 1,0,1,1,0,1,1,1, parity=1, stop=1.
//     - Device ACKs low; done_o pulses once; busy_o falls.
//  2. d_i=0xF4 -> parity bit 0. d_i=0x00 -> parity 1. d_i=0xFF -> parity 1. All data bits must match.
//  3. Device never clocks after release -> err_o pulse 2000 cycles after SETUP ends; both oe=0.
//  4. Device leaves data high at the ACK edge -> err_o pulse; done_o stays 0.
//  5. reset_i=0 after edge 5 -> next cycle c_oe=d_oe=busy_o=0.
//     - After reset is released, a full 0xF4 frame completes normally.
//  6. we_i pulsed during busy with d_i=0x55 -> ignored; the original byte is sent.
//     - we_i in the cycle after done_o is accepted.

Source files
------------

// File: rtl/m_uxa_ps2_txreg_pkg.sv
// Shared definitions for the UXA PS/2 host-to-device transmitter.
// Holds the state encoding, the frame length, default timing and the frame builder.
package m_uxa_ps2_txreg_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INHIBIT = 3'd1,
        ST_SETUP   = 3'd2,
        ST_SHIFT   = 3'd3,
        ST_ACK     = 3'd4,
        ST_RELEASE = 3'd5,
        ST_FAIL    = 3'd6
    } t_tx_state;

    localparam int PS2_FRAME_BITS  = 11;
    localparam int DEF_INHIBIT_CYC = 6000;
    localparam int DEF_TIMEOUT_CYC = 750000;
    localparam int DEF_CNT_W       = 20;

    // Shift payload after the start bit: data LSB first, odd parity, stop.
    function automatic logic [9:0] f_frame(input logic [7:0] d);
        return {1'b1, ~^d, d};
    endfunction

endpackage

// File: rtl/m_uxa_ps2_edgedet.sv
// Two-flop synchronizer for the PS/2 clock/data pins with clock edge pulses.
// Reusable by the receive path; flops reset to the idle (released) level.
module m_uxa_ps2_edgedet
    import m_uxa_ps2_txreg_pkg::*;
(
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_c,
    input  logic i_d,
    output logic o_c,
    output logic o_d,
    output logic o_c_rise,
    output logic o_c_fall
);

    logic [1:0] r_c_sync;
    logic [1:0] r_d_sync;
    logic       r_c_prev;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_c_sync <= 2'b11;
            r_d_sync <= 2'b11;
            r_c_prev <= 1'b1;
        end else begin
            r_c_sync <= {r_c_sync[0], i_c};
            r_d_sync <= {r_d_sync[0], i_d};
            r_c_prev <= r_c_sync[1];
        end
    end

    assign o_c      = r_c_sync[1];
    assign o_d      = r_d_sync[1];
    assign o_c_fall = r_c_prev & ~r_c_sync[1];
    assign o_c_rise = ~r_c_prev & r_c_sync[1];

endmodule

// File: rtl/m_uxa_ps2_txreg.sv
// Host-to-device PS/2 transmitter: inhibits the bus, sends one byte with odd
// parity on device clock falls, checks the device ACK, and reports done/err.
module m_uxa_ps2_txreg
    import m_uxa_ps2_txreg_pkg::*;
#(
    parameter int INHIBIT_CYC = DEF_INHIBIT_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  logic       sys_clk_i,
    input  logic       reset_i,
    input  logic [7:0] d_i,
    input  logic       we_i,
    output logic       busy_o,
    output logic       done_o,
    output logic       err_o,
    input  logic       ps2_c_i,
    input  logic       ps2_d_i,
    output logic       ps2_c_oe_o,
    output logic       ps2_d_oe_o
);

    localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYC - 1);
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [3:0]       LAST_BIT = 4'(PS2_FRAME_BITS - 2);

    t_tx_state        r_state, w_state_nxt;
    logic [9:0]       r_tx, w_tx_nxt;
    logic [3:0]       r_bitcnt, w_bitcnt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             r_c_oe, w_c_oe_nxt;
    logic             r_d_oe, w_d_oe_nxt;
    logic             r_done, w_done_nxt;
    logic             r_err, w_err_nxt;

    logic w_c_sync, w_d_sync, w_c_fall, w_c_rise_unused;

    m_uxa_ps2_edgedet u_edgedet (
        .i_clk    (sys_clk_i),
        .i_rst_n  (reset_i),
        .i_c      (ps2_c_i),
        .i_d      (ps2_d_i),
        .o_c      (w_c_sync),
        .o_d      (w_d_sync),
        .o_c_rise (w_c_rise_unused),
        .o_c_fall (w_c_fall)
    );

    always_comb begin
        w_state_nxt  = r_state;
        w_tx_nxt     = r_tx;
        w_bitcnt_nxt = r_bitcnt;
        w_cnt_nxt    = r_cnt;
        w_c_oe_nxt   = r_c_oe;
        w_d_oe_nxt   = r_d_oe;
        w_done_nxt   = 1'b0;
        w_err_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_c_oe_nxt = 1'b0;
                w_d_oe_nxt = 1'b0;
                if (we_i) begin
                    w_tx_nxt    = f_frame(d_i);
                    w_cnt_nxt   = '0;
                    w_c_oe_nxt  = 1'b1;
                    w_state_nxt = ST_INHIBIT;
                end
            end
            ST_INHIBIT: begin
                w_c_oe_nxt = 1'b1;
                if (r_cnt == INH_LAST) begin
                    w_d_oe_nxt  = 1'b1;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_SETUP;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_SETUP: begin
                w_c_oe_nxt   = 1'b0;
                w_bitcnt_nxt = '0;
                w_cnt_nxt    = '0;
                w_state_nxt  = ST_SHIFT;
            end
            ST_SHIFT: begin
                // Open-drain: a 1 bit is sent by releasing the line.
                if (w_c_fall) begin
                    w_d_oe_nxt   = ~r_tx[r_bitcnt];
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                    w_cnt_nxt    = '0;
                    if (r_bitcnt == LAST_BIT) begin
                        w_state_nxt = ST_ACK;
                    end
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_ACK: begin
                if (w_c_fall) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_d_sync ? ST_FAIL : ST_RELEASE;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (w_c_sync && w_d_sync) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else if (r_cnt == TMO_LAST) begin
                    w_state_nxt = ST_FAIL;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end
            ST_FAIL: begin
                w_c_oe_nxt  = 1'b0;
                w_d_oe_nxt  = 1'b0;
                w_err_nxt   = 1'b1;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_c_oe_nxt  = 1'b0;
                w_d_oe_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge sys_clk_i) begin
        if (!reset_i) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_cnt    <= '0;
            r_c_oe   <= 1'b0;
            r_d_oe   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_bitcnt <= w_bitcnt_nxt;
            r_cnt    <= w_cnt_nxt;
            r_c_oe   <= w_c_oe_nxt;
            r_d_oe   <= w_d_oe_nxt;
            r_done   <= w_done_nxt;
            r_err    <= w_err_nxt;
        end
    end

    // Frame payload is only read in SHIFT, after it has been loaded.
    always_ff @(posedge sys_clk_i) begin
        r_tx <= w_tx_nxt;
    end

    assign busy_o     = (r_state != ST_IDLE);
    assign done_o     = r_done;
    assign err_o      = r_err;
    assign ps2_c_oe_o = r_c_oe;
    assign ps2_d_oe_o = r_d_oe;

endmodule

// File: tb/tb_m_uxa_ps2_txreg.sv
// Bench for m_uxa_ps2_txreg: a PS/2 device model clocks frames out of the host
// and checks them, plus done/err outcomes, against scoreboard queues.
module tb_m_uxa_ps2_txreg;

    localparam int HALF = 200;

    logic       clk;
    logic       rst_n;
    logic [7:0] d;
    logic       we;
    logic       busy, done, err;
    logic       c_oe, d_oe;
    logic       dev_c, dev_d;
    logic       ps2_c, ps2_d;

    int n_chk   = 0;
    int n_fail  = 0;
    int n_pulse = 0;
    int exp_pulses = 0;

    logic [10:0] frame_q[$];
    logic [1:0]  out_q[$];

    assign ps2_c = dev_c & ~c_oe;
    assign ps2_d = dev_d & ~d_oe;

    m_uxa_ps2_txreg #(
        .INHIBIT_CYC (60),
        .TIMEOUT_CYC (2000),
        .CNT_W       (20)
    ) dut (
        .sys_clk_i  (clk),
        .reset_i    (rst_n),
        .d_i        (d),
        .we_i       (we),
        .busy_o     (busy),
        .done_o     (done),
        .err_o      (err),
        .ps2_c_i    (ps2_c),
        .ps2_d_i    (ps2_d),
        .ps2_c_oe_o (c_oe),
        .ps2_d_oe_o (d_oe)
    );

    initial clk = 1'b0;
    always #100 clk = ~clk;

    task automatic check_val(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [10:0] exp_frame(input logic [7:0] b);
        logic [7:0] tmp;
        int         ones;
        logic       par;
        tmp  = b;
        ones = 0;
        repeat (8) begin
            ones += int'(tmp[0]);
            tmp = tmp >> 1;
        end
        par = ((ones % 2) == 0);
        return {1'b1, par, b, 1'b0};
    endfunction

    always @(negedge clk) begin
        if (rst_n && (done || err)) begin
            n_pulse++;
            check_val("pulse_exclusive", int'(done & err), 0);
            check_val("busy_at_pulse", int'(busy), 0);
            check_val("oe_at_pulse", int'({c_oe, d_oe}), 0);
            if (out_q.size() == 0) begin
                check_val("unexpected_pulse", int'({done, err}), 0);
            end else begin
                check_val("outcome", int'({done, err}), int'(out_q.pop_front()));
            end
        end
    end

    task automatic send(input logic [7:0] b, input bit pf, input bit po, input logic [1:0] kind);
        we = 1'b1;
        d  = b;
        if (pf) frame_q.push_back(exp_frame(b));
        if (po) begin
            out_q.push_back(kind);
            exp_pulses++;
        end
        @(negedge clk);
        we = 1'b0;
        d  = 8'h00;
        check_val("accept_busy", int'(busy), 1);
    endtask

    task automatic dev_run(input int n_pulses, input bit do_ack, input bit poke_we);
        int          t;
        int          inh;
        int          setup;
        logic [10:0] got;
        got = '0;
        t = 0;
        while (!c_oe && t < 20) begin
            @(negedge clk);
            t++;
        end
        inh = 0;
        while (c_oe && !d_oe && inh < 200) begin
            @(negedge clk);
            inh++;
        end
        check_val("inhibit_cycles", inh, 60);
        setup = 0;
        while (c_oe && d_oe && setup < 20) begin
            @(negedge clk);
            setup++;
        end
        check_val("setup_cycles", setup, 1);
        if (n_pulses == 0) return;
        repeat (20) @(negedge clk);
        got = {ps2_d, got[10:1]};
        for (int k = 1; k <= n_pulses; k++) begin
            if (k == 11 && do_ack) begin
                dev_d = 1'b0;
                repeat (10) @(negedge clk);
            end
            dev_c = 1'b0;
            if (poke_we && k == 3) begin
                we = 1'b1;
                d  = 8'h55;
                @(negedge clk);
                we = 1'b0;
                d  = 8'h00;
            end
            repeat (HALF) @(negedge clk);
            dev_c = 1'b1;
            if (k <= 10) got = {ps2_d, got[10:1]};
            repeat (HALF) @(negedge clk);
        end
        dev_d = 1'b1;
        if (n_pulses == 11) begin
            if (frame_q.size() == 0) begin
                check_val("frame_unexpected", int'(got), 0);
            end else begin
                check_val("frame_bits", int'(got), int'(frame_q.pop_front()));
            end
        end
    endtask

    task automatic wait_outcome();
        int t;
        t = 0;
        while (n_pulse < exp_pulses && t < 1000) begin
            @(negedge clk);
            t++;
        end
        check_val("outcome_seen", n_pulse, exp_pulses);
        @(negedge clk);
    endtask

    initial begin
        #18000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq_q[$];
        logic [7:0] b;
        int         t;
        rst_n = 1'b0;
        we    = 1'b0;
        d     = 8'h00;
        dev_c = 1'b1;
        dev_d = 1'b1;
        repeat (3) @(negedge clk);
        check_val("reset_outputs", int'({busy, done, err, c_oe, d_oe}), 0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        seq_q = '{8'hED, 8'hF4, 8'h00, 8'hFF};
        while (seq_q.size() > 0) begin
            b = seq_q.pop_front();
            send(b, 1'b1, 1'b1, 2'b10);
            dev_run(11, 1'b1, 1'b0);
            wait_outcome();
        end

        // Device never clocks: timeout from the end of SETUP.
        send(8'hA5, 1'b0, 1'b1, 2'b01);
        dev_run(0, 1'b0, 1'b0);
        t = 0;
        while (!err && t < 3000) begin
            @(negedge clk);
            t++;
        end
        check_val("timeout_window", int'(t >= 1996 && t <= 2006), 1);
        wait_outcome();

        // Device leaves data high at the ACK edge.
        send(8'h3C, 1'b1, 1'b1, 2'b01);
        dev_run(11, 1'b0, 1'b0);
        wait_outcome();

        // Reset after the fifth clock fall.
        send(8'hED, 1'b0, 1'b0, 2'b00);
        dev_run(5, 1'b1, 1'b0);
        check_val("busy_mid_frame", int'(busy), 1);
        rst_n = 1'b0;
        @(negedge clk);
        check_val("reset_mid_frame", int'({c_oe, d_oe, busy}), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        send(8'hF4, 1'b1, 1'b1, 2'b10);
        dev_run(11, 1'b1, 1'b0);
        wait_outcome();

        // Request during busy is ignored; next request right after done.
        send(8'h96, 1'b1, 1'b1, 2'b10);
        dev_run(11, 1'b1, 1'b1);
        wait_outcome();
        send(8'h0F, 1'b1, 1'b1, 2'b10);
        dev_run(11, 1'b1, 1'b0);
        wait_outcome();

        repeat (10) @(negedge clk);
        check_val("outcome_q_empty", out_q.size(), 0);
        check_val("frame_q_empty", frame_q.size(), 0);
        check_val("pulse_total", n_pulse, exp_pulses);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
